// File: rtl/s3_writeback_regfile.sv
// Architectural register file fed by the S3 pipeline register; r0 reads zero.
// Define REGFILE_BYPASS_EN for same-cycle write-through onto the read ports.
module s3_writeback_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ReadSelect1,
  input  logic [ADDR_WIDTH-1:0] ReadSelect2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] WriteSelect,
  input  logic                  WriteEnable,
  output logic [31:0]           WriteCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [31:0]           cnt_q;
  logic [31:0]           cnt_d;
  logic                  commit;

  assign commit = WriteEnable && (WriteSelect != '0);
  assign cnt_d  = commit ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (commit) begin
        regs_q[WriteSelect] <= WriteData;
      end
      cnt_q <= cnt_d;
    end
  end

  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  assign rd1 = (ReadSelect1 == '0) ? '0 : regs_q[ReadSelect1];
  assign rd2 = (ReadSelect2 == '0) ? '0 : regs_q[ReadSelect2];

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // commit already excludes r0, so the bypass never leaks into index 0
  assign byp1 = !rst && commit && (ReadSelect1 == WriteSelect);
  assign byp2 = !rst && commit && (ReadSelect2 == WriteSelect);

  assign ReadData1 = byp1 ? WriteData : rd1;
  assign ReadData2 = byp2 ? WriteData : rd2;
`else
  assign ReadData1 = rd1;
  assign ReadData2 = rd2;
`endif

  assign WriteCount = cnt_q;

endmodule

// File: doc/s3_writeback_regfile.md
# s3_writeback_regfile

Architectural register file for the 3-stage pipeline CPU. It sits directly downstream of the S3 pipeline register: it consumes the registered ALU result, destination select and write enable, and commits them on the next rising edge. It also serves two combinational read ports to the S1 decode stage and keeps a count of committed writes for bench and debug visibility.

## Interface

- DATA_WIDTH, 32, register and data width.
- ADDR_WIDTH, 5, select width; depth is 2**ADDR_WIDTH (32 registers).

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately on assertion.
- ReadSelect1  input  ADDR_WIDTH  port 1 register index (from S1).
- ReadSelect2  input  ADDR_WIDTH  port 2 register index (from S1).
- ReadData1  output  DATA_WIDTH  port 1 data, combinational.
- ReadData2  output  DATA_WIDTH  port 2 data, combinational.
- WriteData  input  DATA_WIDTH  write-back value (driven by ALUOut).
- WriteSelect  input  ADDR_WIDTH  destination index (driven by S3_WriteSelect).
- WriteEnable  input  1  write strobe (driven by S3_WriteEnable).
- WriteCount  output  32  number of committed writes since reset.

## Operation

- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits each. Register 0 is hardwired to zero.
- Write: on a rising clk edge with rst low, WriteEnable=1 and WriteSelect!=0, the register at WriteSelect <= WriteData.
- Write with WriteSelect=0 is discarded. It is not counted.
- WriteEnable=0: no state change and no count.
- Read: ReadDataN = register[ReadSelectN]. It is a pure mux of stored state, plus the bypass when configured. Index 0 always reads 0.
- Both ports may read the same index simultaneously; both return identical data.
- WriteCount increments by 1 on each committed write. It is modular 32-bit: 0xFFFFFFFF + 1 wraps to 0x00000000 with no saturation or flag.
- Reset: asserting rst clears all registers and WriteCount to 0 immediately, without waiting for a clock edge.
  - While rst is high, writes are ignored, and ReadData1, ReadData2 and WriteCount read 0.
  - Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Deassertion: the first write commits on the first rising edge at which rst is sampled low.

## Timing

- Write latency: WriteData is visible on a read port the cycle after the commit edge. With REGFILE_BYPASS_EN, it is visible in the same cycle; see Configuration.
- Read latency: 0 cycles (combinational from ReadSelect and stored state).
- WriteCount updates on the same edge as the commit it counts.
- No handshake: the upstream S3 register presents one write per cycle, and every cycle is accepted.
- Reset values:
  - all registers 0
  - WriteCount 0
  - ReadData1 and ReadData2 read 0 as a consequence of the cleared storage.

## Configuration

- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass): when WriteEnable=1, WriteSelect!=0 and ReadSelectN==WriteSelect, ReadDataN = WriteData combinationally in the same cycle. This closes the S1-read / S3-write hazard in the 3-stage pipeline. The bypass is gated off while rst is high.
- Undefined: reads return only stored state. A read of the index being written returns the old value until after the commit edge. Software or the bench must insert a stall cycle.

## Test plan

- Reset: pulse rst mid-cycle, asynchronously, after writing 0xDEADBEEF to r5.
  - ReadData1 with ReadSelect1=5 drops to 0 without a clock edge.
  - WriteCount = 0.
- Basic write/read: write 0x12345678 to r7 and 0xCAFEF00D to r31 on consecutive edges, then read r7 on port 1 and r31 on port 2.
  - Ports return 0x12345678 and 0xCAFEF00D.
  - WriteCount = 2.
- r0 protection: WriteEnable=1, WriteSelect=0, WriteData=0xFFFFFFFF.
  - ReadData on index 0 stays 0.
  - WriteCount is unchanged.
- Same-cycle hazard: r3 holds 0x11; in one cycle drive a write of 0x22 to r3 and ReadSelect1=3.
  - With REGFILE_BYPASS_EN: ReadData1=0x22 before the edge.
  - Without it: 0x11 before the edge, 0x22 after.
- WriteEnable low: drive WriteSelect=9, WriteData=0xAAAA5555, WriteEnable=0 for 3 cycles.
  - r9 stays 0.
  - WriteCount is unchanged.
- Counter wrap: force WriteCount to 0xFFFFFFFE via 2 writes after preloading through a hierarchical deposit, then perform 2 more writes.
  - WriteCount reads 0x00000000.
